alu_exec_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 35 +++
 rtl/seq_mul32.sv | 71 +++++++
 rtl/alu_exec_stage.sv | 183 ++++++++++++++++++
 tb/tb_alu_exec_stage.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU execute stage.
//   - opcode encodings (OP_ADD..OP_MUL; 0xB-0xF reserved)
//   - execute-stage FSM states
//   - bit positions inside the {N,Z,C,V} flags vector
//   - op_writes(): whether an opcode requests a register write
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_ORR = 4'h3;
  localparam logic [3:0] OP_EOR = 4'h4;
  localparam logic [3:0] OP_MVN = 4'h5;
  localparam logic [3:0] OP_LSL = 4'h6;
  localparam logic [3:0] OP_LSR = 4'h7;
  localparam logic [3:0] OP_MOV = 4'h8;
  localparam logic [3:0] OP_CMP = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam int unsigned FLG_N = 3;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

  // CMP only updates flags; reserved opcodes write nothing.
  function automatic logic op_writes(input logic [3:0] op);
    return (op <= OP_MUL) && (op != OP_CMP);
  endfunction

endpackage

// File: rtl/seq_mul32.sv
// seq_mul32: iterative shift-add unsigned multiplier, low WIDTH bits of a*b.
//   clk, rst_n : clock, asynchronous active-low reset (aborts any operation)
//   start      : latch a/b and begin (ignored while busy)
//   a, b       : multiplicand / multiplier
//   busy       : iterations in progress
//   done       : high during the cycle whose closing edge is the final iteration
//   product    : accumulator value as of that edge; valid to capture when done=1
// One multiplier bit (LSB first) is consumed per clock edge after start.
module seq_mul32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITERS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(ITERS) + 1;

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [WIDTH-1:0] w_partial;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  assign w_partial  = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_partial;
  assign w_last     = r_busy && (r_cnt == CNT_W'(ITERS - 1));

  // done/product are combinational so the consumer can register the final
  // product on the same edge that performs the last iteration.
  assign busy    = r_busy;
  assign done    = w_last;
  assign product = w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (w_last) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (start) begin
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage between register-bank read muxes and the
// LDR write-back mux. Single-cycle ALU ops have latency 1; MUL iterates
// MUL_CYCLES cycles in seq_mul32.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake (opcode, source_1, source_2, dest_in)
//   out_valid/out_ready : downstream handshake (result, dest_out, wr_en, flags)
//   wr_en               : out_valid and the op writes a register
//   flags               : {N,Z,C,V}
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] source_1,
  input  logic [WIDTH-1:0] source_2,
  input  logic [3:0]       dest_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       dest_out,
  output logic             wr_en,
  output logic [3:0]       flags
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_dest;
  logic             r_wr;
  logic [3:0]       r_flags;
  logic [3:0]       r_mul_dest;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_mul_start;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;

  logic [SH_W-1:0]  w_amt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH:0]   w_lsl_wide;
  logic [WIDTH:0]   w_lsr_wide;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_keep_flags;
  logic [3:0]       w_flags;

  assign w_in_ready  = (r_state == ST_IDLE) && !w_mul_busy && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && w_in_ready;
  assign w_mul_start = w_accept && (opcode == OP_MUL);

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign dest_out  = r_dest;
  assign wr_en     = r_out_valid && r_wr;
  assign flags     = r_flags;

  seq_mul32 #(
    .WIDTH (WIDTH),
    .ITERS (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mul_start),
    .a       (source_1),
    .b       (source_2),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_mul_product)
  );

  // Shifts are done one bit wider so the last bit shifted out lands in the
  // extra bit; an amount of zero leaves that bit 0, giving C=0 for free.
  assign w_amt      = source_2[SH_W-1:0];
  assign w_sum      = {1'b0, source_1} + {1'b0, source_2};
  assign w_diff     = source_1 - source_2;
  assign w_lsl_wide = {1'b0, source_1} << w_amt;
  assign w_lsr_wide = {source_1, 1'b0} >> w_amt;

  always_comb begin
    w_res        = '0;
    w_c          = 1'b0;
    w_v          = 1'b0;
    w_keep_flags = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (source_1[WIDTH-1] == source_2[WIDTH-1]) &&
                (w_sum[WIDTH-1] != source_1[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        w_res = w_diff;
        w_c   = (source_1 >= source_2);
        w_v   = (source_1[WIDTH-1] != source_2[WIDTH-1]) &&
                (w_diff[WIDTH-1] != source_1[WIDTH-1]);
      end
      OP_AND: w_res = source_1 & source_2;
      OP_ORR: w_res = source_1 | source_2;
      OP_EOR: w_res = source_1 ^ source_2;
      OP_MVN: w_res = ~source_2;
      OP_LSL: begin
        w_res = w_lsl_wide[WIDTH-1:0];
        w_c   = w_lsl_wide[WIDTH];
      end
      OP_LSR: begin
        w_res = w_lsr_wide[WIDTH:1];
        w_c   = w_lsr_wide[0];
      end
      OP_MOV: w_res = source_2;
      OP_MUL: w_res = '0;
      default: w_keep_flags = 1'b1;
    endcase

    w_flags = r_flags;
    if (!w_keep_flags) begin
      w_flags[FLG_N] = w_res[WIDTH-1];
      w_flags[FLG_Z] = (w_res == '0);
      w_flags[FLG_C] = w_c;
      w_flags[FLG_V] = w_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_dest      <= '0;
      r_wr        <= 1'b0;
      r_flags     <= '0;
      r_mul_dest  <= '0;
    end else begin
      // Consumption first; a same-edge accept below takes precedence.
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (opcode == OP_MUL) begin
              r_state    <= ST_MUL;
              r_mul_dest <= dest_in;
            end else begin
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_dest      <= dest_in;
              r_wr        <= op_writes(opcode);
              r_flags     <= w_flags;
            end
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_state        <= ST_IDLE;
            r_out_valid    <= 1'b1;
            r_result       <= w_mul_product;
            r_dest         <= r_mul_dest;
            r_wr           <= 1'b1;
            r_flags[FLG_N] <= w_mul_product[WIDTH-1];
            r_flags[FLG_Z] <= (w_mul_product == '0);
            r_flags[FLG_C] <= 1'b0;
            r_flags[FLG_V] <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [31:0] source_1;
  logic [31:0] source_2;
  logic [3:0]  dest_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  dest_out;
  logic        wr_en;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .source_1  (source_1),
    .source_2  (source_2),
    .dest_in   (dest_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .dest_out  (dest_out),
    .wr_en     (wr_en),
    .flags     (flags)
  );

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [3:0]  dest;
    logic        wr;
    logic [3:0]  flg;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_fail = 0;
  logic [3:0]  prev_flg;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: 64-bit / signed-range arithmetic, bit-indexed shift carry.
  function automatic exp_t model(input string tag, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] d, input logic [3:0] prev);
    exp_t        e;
    logic [63:0] w;
    longint      sr;
    int unsigned amt;
    logic        c;
    logic        v;
    amt = 32'(b[4:0]);
    c = 1'b0;
    v = 1'b0;
    e.tag = tag;
    e.dest = d;
    e.wr = 1'b1;
    e.res = '0;
    case (op)
      4'h0: begin
        w = {32'b0, a} + {32'b0, b};
        e.res = w[31:0];
        c = w[32];
        sr = longint'($signed(a)) + longint'($signed(b));
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'h1, 4'h9: begin
        e.res = a - b;
        c = (a >= b);
        sr = longint'($signed(a)) - longint'($signed(b));
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        if (op == 4'h9) e.wr = 1'b0;
      end
      4'h2: e.res = a & b;
      4'h3: e.res = a | b;
      4'h4: e.res = a ^ b;
      4'h5: e.res = ~b;
      4'h6: begin
        e.res = a << amt;
        c = (amt == 0) ? 1'b0 : a[32 - amt];
      end
      4'h7: begin
        e.res = a >> amt;
        c = (amt == 0) ? 1'b0 : a[amt - 1];
      end
      4'h8: e.res = b;
      4'hA: begin
        w = {32'b0, a} * {32'b0, b};
        e.res = w[31:0];
      end
      default: begin
        e.wr = 1'b0;
        e.flg = prev;
        return e;
      end
    endcase
    e.flg = {e.res[31], (e.res == 32'h0), c, v};
    return e;
  endfunction

  // Scoreboard: compare each result as it is consumed downstream.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {31'b0, out_valid}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, ".result"}, result, mon_e.res);
        check({mon_e.tag, ".dest"}, {28'b0, dest_out}, {28'b0, mon_e.dest});
        check({mon_e.tag, ".wr_en"}, {31'b0, wr_en}, {31'b0, mon_e.wr});
        check({mon_e.tag, ".flags"}, {28'b0, flags}, {28'b0, mon_e.flg});
      end
    end
  end

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] d);
    exp_t e;
    opcode   = op;
    source_1 = a;
    source_2 = b;
    dest_in  = d;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) begin
      check({tag, ".accept_timeout"}, {31'b0, in_ready}, 32'h1);
      in_valid = 1'b0;
      return;
    end
    e = model(tag, op, a, b, d, prev_flg);
    sb.push_back(e);
    prev_flg = e.flg;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output logic ir_seen);
    lat = 0;
    ir_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ir_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".out_valid"}, {31'b0, out_valid}, 32'h0);
    check({tag, ".result"}, result, 32'h0);
    check({tag, ".dest_out"}, {28'b0, dest_out}, 32'h0);
    check({tag, ".wr_en"}, {31'b0, wr_en}, 32'h0);
    check({tag, ".flags"}, {28'b0, flags}, 32'h0);
    check({tag, ".in_ready"}, {31'b0, in_ready}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        ir_seen;
    logic        ov_seen;
    int unsigned c0;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = '0;
    source_1  = '0;
    source_2  = '0;
    dest_in   = '0;
    prev_flg  = '0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_init");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Mid-stream reset with a held, unconsumed result.
    out_ready = 1'b0;
    do_op("pre_rst", OP_ADD, 32'd5, 32'd6, 4'd7);
    check("pre_rst.out_valid", {31'b0, out_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    prev_flg = '0;
    #1;
    check_reset_outputs("reset_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Back-to-back single-cycle ops: one accept per cycle.
    c0 = cyc;
    do_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 4'd3);
    check("add_wrap.latency1", {31'b0, out_valid}, 32'h1);
    do_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 4'd4);
    do_op("cmp_5_7", OP_CMP, 32'd5, 32'd7, 4'd1);
    do_op("lsl_1", OP_LSL, 32'h8000_0001, 32'h1, 4'd2);
    do_op("lsr_21", OP_LSR, 32'h1, 32'h21, 4'd5);
    do_op("lsl_0", OP_LSL, 32'h1234_5678, 32'h20, 4'd6);
    do_op("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 4'd7);
    do_op("orr", OP_ORR, 32'hA000_0001, 32'h0500_0010, 4'd8);
    do_op("eor", OP_EOR, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'd9);
    do_op("mvn", OP_MVN, 32'h0, 32'h0000_FFFF, 4'd10);
    do_op("reserved_c", 4'hC, 32'h1, 32'h2, 4'd11);
    do_op("add_vovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 4'd12);
    do_op("mov", OP_MOV, 32'h1, 32'h8765_4321, 4'd13);
    check("throughput_cycles", cyc - c0, 32'd13);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    // MUL latency and in_ready low while iterating.
    do_op("mul_10001", OP_MUL, 32'h0001_0001, 32'h0001_0001, 4'd5);
    wait_out(lat, ir_seen);
    check("mul_10001.latency", lat, 32'd32);
    check("mul_10001.in_ready_low", {31'b0, ir_seen}, 32'h0);
    @(posedge clk);
    #1;
    do_op("mul_ffff", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6);
    wait_out(lat, ir_seen);
    check("mul_ffff.latency", lat, 32'd32);
    @(posedge clk);
    #1;

    // Backpressure: result held 5 cycles, then release with a new op pending.
    out_ready = 1'b0;
    do_op("bp_add", OP_ADD, 32'h10, 32'h20, 4'd9);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp.out_valid", {31'b0, out_valid}, 32'h1);
      check("bp.result", result, 32'h30);
      check("bp.dest_out", {28'b0, dest_out}, 32'd9);
      check("bp.wr_en", {31'b0, wr_en}, 32'h1);
      check("bp.flags", {28'b0, flags}, 32'h0);
      check("bp.in_ready", {31'b0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    c0 = cyc;
    do_op("bp_next", OP_SUB, 32'h30, 32'h10, 4'd10);
    check("bp_next.accept_cycles", cyc - c0, 32'd1);
    check("bp_next.out_valid", {31'b0, out_valid}, 32'h1);
    @(posedge clk);
    #1;

    // Reset during MUL at iteration 10.
    do_op("mul_abort", OP_MUL, 32'd3, 32'd4, 4'd2);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    prev_flg = '0;
    #1;
    check("mul_abort.out_valid", {31'b0, out_valid}, 32'h0);
    check("mul_abort.in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ov_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_seen = 1'b1;
    end
    check("mul_abort.no_output", {31'b0, ov_seen}, 32'h0);
    check("mul_abort.idle_ready", {31'b0, in_ready}, 32'h1);
    do_op("post_add", OP_ADD, 32'd2, 32'd3, 4'd1);
    check("post_add.out_valid", {31'b0, out_valid}, 32'h1);
    @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
